fact_job_arbiter: RTL

- Shares one factorial accelerator (CU plus datapath) between NREQ requesters.
- Round-robin picks one pending job, latches its operand, and drives the accelerator with a level go/done handshake.
- Routes the result back to the winning requester as a one-cycle response pulse.
- A watchdog aborts any job whose done never arrives.

---
 rtl/fact_pkg.sv | 16 +
 rtl/fact_rr_pick.sv | 30 +++
 rtl/fact_job_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared state encoding and default widths for the factorial job arbiter
package fact_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam int FACT_NW      = 4;
    localparam int FACT_RW      = 32;
    localparam int FACT_TIMEOUT = 255;

endpackage

// File: rtl/fact_rr_pick.sv
// rtl/fact_rr_pick.sv - rotate-priority encoder: first set req bit at or above ptr, wrapping
module fact_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  id
);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] rot;

    assign dbl = {req, req};
    assign rot = dbl >> ptr;

    // Scan downward so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                id    = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fact_job_arbiter.sv
// rtl/fact_job_arbiter.sv - round-robin sharing of one factorial accelerator with watchdog abort
module fact_job_arbiter
    import fact_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NW      = FACT_NW,
    parameter int RW      = FACT_RW,
    parameter int TIMEOUT = FACT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*NW-1:0] n_in,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [RW-1:0]    rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic             acc_go,
    output logic [NW-1:0]    acc_n,
    input  logic             acc_done,
    input  logic [RW-1:0]    acc_result,
    input  logic             acc_ovf
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [NW-1:0]     acc_n_q, acc_n_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]     rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic              acc_go_q, acc_go_d;
    logic [WDW-1:0]    wd_q, wd_d;

    logic              pick_valid;
    logic [IDW-1:0]    pick_id;

    fact_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        acc_n_d     = acc_n_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        acc_go_d    = acc_go_q;
        wd_d        = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    id_d    = pick_id;
                    acc_n_d = n_in[pick_id*NW +: NW];
                    gnt_d   = ONE << pick_id;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: state_d = ST_ARM;
            ST_ARM: begin
                // A done still high from the previous job must fall before we start.
                if (!acc_done) begin
                    acc_go_d = 1'b1;
                    wd_d     = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (acc_done) begin
                    rsp_data_d  = acc_result;
                    rsp_err_d   = acc_ovf;
                    acc_go_d    = 1'b0;
                    rsp_valid_d = ONE << id_q;
                    state_d     = ST_RESP;
                end else if (wd_q == WDW'(TIMEOUT)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    acc_go_d    = 1'b0;
                    rsp_valid_d = ONE << id_q;
                    state_d     = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: begin
                ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            acc_n_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            acc_go_q    <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            acc_n_q     <= acc_n_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            acc_go_q    <= acc_go_d;
            wd_q        <= wd_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign acc_go    = acc_go_q;
    assign acc_n     = acc_n_q;

endmodule
